// File: rtl/apb_if.sv
// apb_if: APB3 bus signals between a requester and one target.
// master drives select/enable/direction/address/write data; slave returns
// read data, ready and error.
interface apb_if;
  logic        psel_in;
  logic        penable_in;
  logic        pwrite_in;
  logic [31:0] paddr_in;
  logic [31:0] pwdata_in;
  logic [31:0] prdata_out;
  logic        pready_out;
  logic        pslverr_out;

  modport master (
    output psel_in, penable_in, pwrite_in, paddr_in, pwdata_in,
    input  prdata_out, pready_out, pslverr_out
  );

  modport slave (
    input  psel_in, penable_in, pwrite_in, paddr_in, pwdata_in,
    output prdata_out, pready_out, pslverr_out
  );
endinterface

// File: rtl/apb_regbank.sv
// apb_regbank: APB3 target with a bank of R/W registers followed by read-only
// status words, programmable wait states, PSLVERR and per-register write pulses.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           apb_if.slave; prdata/pready/pslverr are combinational
//   status_in     status word j at [32j+31:32j] (one unused word if NUM_STATUS=0)
//   regs_out      register i at [32i+31:32i]
//   wr_pulse_out  bit i high for one cycle after register i is written
module apb_regbank #(
  parameter logic [31:0] START_ADDRESS = 32'h8c00_0000,
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned NUM_STATUS    = 2,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  apb_if.slave                                           bus,
  input  logic [32*((NUM_STATUS > 0) ? NUM_STATUS : 1)-1:0] status_in,
  output logic [32*NUM_REGS-1:0]                         regs_out,
  output logic [NUM_REGS-1:0]                            wr_pulse_out
);

  localparam int unsigned IDX_W = 10;
  // 33-bit bounds so an end address at the top of the map cannot wrap.
  localparam logic [32:0] START_A = {1'b0, START_ADDRESS};
  localparam logic [32:0] END_A   = START_A + 33'(4 * (NUM_REGS + NUM_STATUS));

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic              hit, err, is_reg, pready_c, commit_c;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rdata;
  logic [32:0]       addr_ext;

  // Address decode, error detection and transfer completion.
  always_comb begin
    addr_ext = {1'b0, bus.paddr_in};
    hit      = (addr_ext >= START_A) && (addr_ext < END_A);
    idx      = IDX_W'((bus.paddr_in - START_ADDRESS) >> 2);
    is_reg   = (idx < IDX_W'(NUM_REGS));
    err      = hit && ((bus.paddr_in[1:0] != 2'b00) || (bus.pwrite_in && !is_reg));
    pready_c = rst_n && bus.psel_in && bus.penable_in && hit && (wcnt_q == 4'd0);
    commit_c = pready_c && bus.pwrite_in && !err;
  end

  // Read mux over registers then status words.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rdata = regs_q[i];
    end
    for (int unsigned j = 0; j < NUM_STATUS; j++) begin
      if (idx == IDX_W'(NUM_REGS + j)) rdata = status_in[32*j +: 32];
    end
  end

  assign bus.pready_out  = pready_c;
  assign bus.pslverr_out = pready_c && err;
  assign bus.prdata_out  = (pready_c && !bus.pwrite_in && !err) ? rdata : 32'd0;

  // Bus phase tracking, wait counter and register commit.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (!bus.psel_in) begin
      state_d = ST_IDLE;
      wcnt_d  = 4'd0;
    end else if (!bus.penable_in) begin
      state_d = ST_SETUP;
      wcnt_d  = 4'(WAIT_STATES);
    end else begin
      state_d = ST_ACCESS;
      if (hit && (wcnt_q != 4'd0)) wcnt_d = wcnt_q - 4'd1;
    end
    if (commit_c) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) begin
          regs_d[i]     = bus.pwdata_in;
          wr_pulse_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 4'd0;
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = regs_q[g];
  end
  assign wr_pulse_out = wr_pulse_q;

`ifndef SYNTHESIS
  // state_q holds the previous cycle's phase: a setup must be followed by an
  // access, and an access may only follow a setup or another access.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((state_q == ST_SETUP) && !(bus.psel_in && bus.penable_in)) &&
              !((state_q == ST_IDLE) && bus.psel_in && bus.penable_in))
        else $error("apb_regbank: APB phase sequence violated");
    end
  end
`endif

endmodule

// File: tb/tb_apb_regbank.sv
// tb_apb_regbank: three instances (0, 3 and 5 wait states) on gated copies of
// one stimulus bus; expected read data/error/wait count is queued when a
// transfer is launched and checked when the selected target completes it.
module tb_apb_regbank;

  localparam logic [31:0] BASE = 32'h8c00_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  int sel;

  logic [31:0] status_w [2];
  logic [63:0] status_vec;
  logic [31:0] m_regs [3][8];
  exp_t sb_q [$];

  logic [255:0] regs0, regs3, regs5, obs_regs;
  logic [7:0]   pulse0, pulse3, pulse5, obs_pulse;
  logic         obs_pready, obs_pslverr;
  logic [31:0]  obs_prdata;

  int n_vec = 0;
  int n_miss = 0;
  int pulse7_cnt = 0;
  logic pulse7_prev = 1'b0;

  always #5 clk = ~clk;

  apb_if bus0();
  apb_if bus3();
  apb_if bus5();

  assign status_vec = {status_w[1], status_w[0]};

  assign bus0.psel_in = psel && (sel == 0);
  assign bus3.psel_in = psel && (sel == 1);
  assign bus5.psel_in = psel && (sel == 2);
  assign bus0.penable_in = penable;
  assign bus3.penable_in = penable;
  assign bus5.penable_in = penable;
  assign bus0.pwrite_in = pwrite;
  assign bus3.pwrite_in = pwrite;
  assign bus5.pwrite_in = pwrite;
  assign bus0.paddr_in = paddr;
  assign bus3.paddr_in = paddr;
  assign bus5.paddr_in = paddr;
  assign bus0.pwdata_in = pwdata;
  assign bus3.pwdata_in = pwdata;
  assign bus5.pwdata_in = pwdata;

  apb_regbank #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .status_in(status_vec),
    .regs_out(regs0), .wr_pulse_out(pulse0));
  apb_regbank #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .status_in(status_vec),
    .regs_out(regs3), .wr_pulse_out(pulse3));
  apb_regbank #(.WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5.slave), .status_in(status_vec),
    .regs_out(regs5), .wr_pulse_out(pulse5));

  always_comb begin
    case (sel)
      1: begin
        obs_pready = bus3.pready_out; obs_pslverr = bus3.pslverr_out;
        obs_prdata = bus3.prdata_out; obs_regs = regs3; obs_pulse = pulse3;
      end
      2: begin
        obs_pready = bus5.pready_out; obs_pslverr = bus5.pslverr_out;
        obs_prdata = bus5.prdata_out; obs_regs = regs5; obs_pulse = pulse5;
      end
      default: begin
        obs_pready = bus0.pready_out; obs_pslverr = bus0.pslverr_out;
        obs_prdata = bus0.prdata_out; obs_regs = regs0; obs_pulse = pulse0;
      end
    endcase
  end

  // Counts rising edges of register 7's pulse on the zero-wait instance.
  always @(negedge clk) begin
    if (pulse0[7] && !pulse7_prev) pulse7_cnt = pulse7_cnt + 1;
    pulse7_prev = pulse0[7];
  end

  function automatic int ws_of(input int s);
    return (s == 1) ? 3 : ((s == 2) ? 5 : 0);
  endfunction

  function automatic logic [255:0] pack_model(input int s);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = m_regs[s][i];
    return v;
  endfunction

  // Model of an in-range transfer: error, read data and wait count.
  function automatic exp_t predict(input bit wr, input logic [31:0] addr);
    exp_t e;
    logic [31:0] off;
    int idx;
    off     = addr - BASE;
    idx     = int'(off >> 2);
    e.err   = (addr[1:0] != 2'b00) || (wr && idx >= 8);
    e.rdata = 32'd0;
    if (!wr && !e.err) e.rdata = (idx < 8) ? m_regs[sel][idx] : status_w[idx-8];
    e.waits = ws_of(sel);
    return e;
  endfunction

  task automatic reset_model();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 8; i++) m_regs[s][i] = 32'd0;
  endtask

  // One complete transfer starting with its setup cycle; returns one step
  // after the completing edge with the bus idle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e, g;
    int waits;
    bit done;
    e = predict(wr, addr);
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (obs_pready) done = 1'b1;
      else begin
        waits++;
        if (waits > 40) done = 1'b1;
        else begin @(posedge clk); #1; end
      end
    end
    g = sb_q.pop_front();
    n_vec++;
    if (!obs_pready) begin
      n_miss++;
      $display("FAIL xfer_timeout addr=%h pready never rose after %0d cycles", addr, waits);
    end else begin
      n_vec += 3;
      if (waits !== g.waits) begin
        n_miss++;
        $display("FAIL wait_cycles addr=%h got %0d required %0d", addr, waits, g.waits);
      end
      if (obs_pslverr !== g.err) begin
        n_miss++;
        $display("FAIL pslverr addr=%h got %b required %b", addr, obs_pslverr, g.err);
      end
      if (obs_prdata !== g.rdata) begin
        n_miss++;
        $display("FAIL prdata addr=%h got %h required %h", addr, obs_prdata, g.rdata);
      end
      if (wr && !g.err) m_regs[sel][int'((addr - BASE) >> 2)] = data;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_regs(input string name);
    n_vec++;
    if (obs_regs !== pack_model(sel)) begin
      n_miss++;
      $display("FAIL %s regs_out got %h required %h", name, obs_regs, pack_model(sel));
    end
  endtask

  task automatic check_pulse(input string name, input logic [7:0] exp);
    n_vec++;
    if (obs_pulse !== exp) begin
      n_miss++;
      $display("FAIL %s wr_pulse_out got %b required %b", name, obs_pulse, exp);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = BASE; pwdata = 32'd0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({obs_pready, obs_pslverr, obs_prdata} !== 34'd0) begin
      n_miss++;
      $display("FAIL reset_comb_outputs got %b/%b/%h required 0/0/0", obs_pready, obs_pslverr, obs_prdata);
    end
    psel = 1'b0; penable = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check_regs("reset_regs");
      check_pulse("reset_pulse", 8'h00);
    end
    sel = 0;
  endtask

  task automatic test_write_read();
    sel = 0;
    xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF);
    n_vec++;
    if (obs_regs[95:64] !== 32'hDEAD_BEEF) begin
      n_miss++;
      $display("FAIL write_visible regs_out[95:64] got %h required deadbeef", obs_regs[95:64]);
    end
    check_pulse("write_pulse_high", 8'b0000_0100);
    @(posedge clk); #1;
    check_pulse("write_pulse_low", 8'b0000_0000);
    xfer(1'b0, BASE + 32'h8, 32'd0);
    xfer(1'b1, BASE, 32'h0123_4567);
    xfer(1'b1, BASE + 32'h1C, 32'hA5A5_5A5A);
    xfer(1'b0, BASE, 32'd0);
    xfer(1'b0, BASE + 32'h1C, 32'd0);
    check_regs("write_read_regs");
  endtask

  task automatic test_errors();
    sel = 0;
    xfer(1'b1, BASE + 32'h24, 32'hFFFF_FFFF);
    check_regs("status_write_regs");
    check_pulse("status_write_pulse", 8'h00);
    xfer(1'b0, BASE + 32'h6, 32'd0);
    xfer(1'b1, BASE + 32'h9, 32'h1111_1111);
    check_regs("misaligned_write_regs");
    check_pulse("misaligned_write_pulse", 8'h00);
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    sel = 0;
    addrs[0] = BASE + 32'h28;
    addrs[1] = BASE - 32'h4;
    for (int a = 0; a < 2; a++) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addrs[a]; pwdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_vec++;
        if ({obs_pready, obs_pslverr, obs_prdata} !== 34'd0) begin
          n_miss++;
          $display("FAIL out_of_range addr=%h cycle %0d got %b/%b/%h required 0/0/0",
                   addrs[a], c, obs_pready, obs_pslverr, obs_prdata);
        end
        @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      check_regs("out_of_range_regs");
      check_pulse("out_of_range_pulse", 8'h00);
    end
  endtask

  task automatic test_wait_status();
    sel = 1;
    xfer(1'b0, BASE + 32'h20, 32'd0);
    xfer(1'b0, BASE + 32'h24, 32'd0);
    xfer(1'b1, BASE + 32'h14, 32'h5555_AAAA);
    xfer(1'b0, BASE + 32'h14, 32'd0);
    check_regs("wait_write_regs");
  endtask

  task automatic test_reset_abort();
    sel = 2;
    xfer(1'b1, BASE + 32'hC, 32'h0F0F_0F0F);
    check_regs("ws5_write_regs");
    // Reset during the second wait cycle of a write to register 1.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_regs("mid_reset_regs");
    check_pulse("mid_reset_pulse", 8'h00);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_regs("after_reset_regs");
    // Abort: select dropped during a wait cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h0000_0055;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_pulse("abort_pulse", 8'h00);
    end
    @(posedge clk); #1;
    check_regs("abort_regs");
    xfer(1'b1, BASE + 32'h8, 32'h0000_0077);
    check_regs("post_abort_regs");
    xfer(1'b0, BASE + 32'h8, 32'd0);
  endtask

  task automatic test_back_to_back();
    int base_cnt;
    sel = 0;
    @(posedge clk); #1;
    base_cnt = pulse7_cnt;
    for (int v = 1; v <= 4; v++) xfer(1'b1, BASE + 32'h1C, 32'(v));
    @(negedge clk); #1;
    n_vec++;
    if (pulse7_cnt - base_cnt !== 4) begin
      n_miss++;
      $display("FAIL b2b_pulse_count got %0d required 4", pulse7_cnt - base_cnt);
    end
    n_vec++;
    if (obs_regs[255:224] !== 32'd4) begin
      n_miss++;
      $display("FAIL b2b_final_value regs_out[255:224] got %h required 00000004", obs_regs[255:224]);
    end
    check_regs("b2b_regs");
  endtask

  initial begin
    status_w[0] = 32'h1234_5678;
    status_w[1] = 32'hCAFE_F00D;
    test_reset();
    test_write_read();
    test_errors();
    test_out_of_range();
    test_wait_status();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_regbank.md
# apb_regbank

Parametrised APB3 target providing a bank of read/write control registers and read-only status words at a configurable base address. It adds configurable wait states, PSLVERR reporting and per-register write pulses. It sits between the APB bus and a core such as the audioport control logic, and replaces hand-written fixed-range, zero-wait-state decoders.

## Interface
- START_ADDRESS, 32'h8c000000, byte address of register 0 (word-aligned)
- NUM_REGS, 8, number of R/W registers, 1..256
- NUM_STATUS, 2, number of read-only status words, 0..256
- WAIT_STATES, 0, wait cycles inserted in every decoded access, 0..15
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- psel_in  in  1  APB select
- penable_in  in  1  APB enable (access phase)
- pwrite_in  in  1  1 = write, 0 = read
- paddr_in  in  32  APB byte address
- pwdata_in  in  32  write data
- prdata_out  out  32  read data
- pready_out  out  1  transfer complete
- pslverr_out  out  1  transfer error, valid with pready_out
- status_in  in  32*NUM_STATUS  status word j at bits [32j+31:32j]
- regs_out  out  32*NUM_REGS  register i at bits [32i+31:32i]
- wr_pulse_out  out  NUM_REGS  bit i high for one cycle after register i is written

## Operation
- Address map: register i at START_ADDRESS+4i. Status j at START_ADDRESS+4(NUM_REGS+j). END = START_ADDRESS+4(NUM_REGS+NUM_STATUS), exclusive.
- hit = START_ADDRESS <= paddr_in < END. The comparison is done on the full 32 bits.
- When hit=0, the block does not respond: pready_out=0, pslverr_out=0, prdata_out=0, and no state changes.
- Error conditions on a hit: paddr_in[1:0]!=0, or a write into the status region. A transfer with an error completes with pslverr_out=1. It has no register effect and no pulse, and its read data is 0.
- Wait counter wcnt is 4 bits wide.
  - It loads WAIT_STATES in every setup cycle (psel_in=1, penable_in=0).
  - It decrements in each access cycle (psel_in=1, penable_in=1, hit) while nonzero.
  - It clears to 0 whenever psel_in=0.
- State machine:
  - IDLE: psel_in=0.
  - SETUP: psel_in=1, penable_in=0. Next state is ACCESS.
  - ACCESS: waits while wcnt!=0. Completes when wcnt==0, then goes to SETUP if psel_in is still 1, otherwise IDLE.
  - The state is used for protocol checking only. pready_out is derived from wcnt.
- pready_out = psel_in & penable_in & hit & (wcnt==0). This is combinational.
- Write commit occurs at the rising edge where pready_out=1, pwrite_in=1 and there is no error. At that edge the register is updated with pwdata_in and wr_pulse_out[i] is set. wr_pulse_out[i] clears on the next edge unless the same register is written again.
- Read data:
  - prdata_out is a combinational mux, driven only when pready_out=1 & pwrite_in=0 & no error. It is 0 otherwise.
  - status_in is sampled combinationally in the completing cycle.
- Reset (rst_n=0, asynchronous): all registers 0, wcnt=0, state IDLE, wr_pulse_out=0. Combinational outputs follow the inputs but are forced to 0 while rst_n=0.

## Timing
- Zero wait states: setup cycle, then access cycle with pready_out=1. The write is visible on regs_out one edge after the access cycle. Each transfer is 2 cycles.
- N wait states: the access phase lasts N+1 cycles. pready_out is low for N cycles and high in cycle N+1.
- Back-to-back transfers: a new setup cycle directly after the completing access cycle reloads wcnt. There are no idle cycles between transfers.
- psel_in dropped mid-wait (protocol abort): wcnt clears, no write occurs, no pulse.
- Writes to the same register in consecutive transfers: each commit produces its own pulse. Pulses are never merged or lost.
- Reset asserted mid-transfer: everything clears immediately. After release, the next transfer starts with a fresh setup cycle.
- NUM_STATUS=0: the status region is empty and END = START_ADDRESS+4·NUM_REGS.

## Test plan
- Defaults, WAIT_STATES=0: write 32'hDEADBEEF to 32'h8c000008, then read it back.
  - Required: regs_out[95:64]=32'hDEADBEEF one edge after the access cycle.
  - Required: wr_pulse_out=8'b00000100 for exactly 1 cycle.
  - Required: the readback returns 32'hDEADBEEF with pready_out high in the first access cycle.
- WAIT_STATES=3: read 32'h8c000020 (status 0) with status_in[31:0]=32'h12345678.
  - Required: pready_out low for 3 access cycles and high in the 4th.
  - Required: prdata_out=32'h12345678 and pslverr_out=0.
- Error cases:
  - Write to 32'h8c000024 (status 1): pslverr_out=1 and regs_out unchanged.
  - Read 32'h8c000006 (misaligned): pslverr_out=1 and prdata_out=0.
- Out-of-range access: psel_in/penable_in held at 32'h8c000028 and at 32'h8bfffffc for 5 cycles. Required: pready_out=0 throughout and no state change.
- Reset and abort, WAIT_STATES=5:
  - rst_n low during the 2nd wait cycle of a write: regs_out=0, wr_pulse_out=0 immediately, no commit.
  - psel_in dropped in a wait cycle of a separate write: no commit.
- Back-to-back writes: 4 consecutive zero-wait writes to register 7 with values 1, 2, 3, 4. Required: 4 distinct wr_pulse_out[7] pulses and regs_out[255:224]=4 at the end.
